// File: rtl/unified_mem_responder.sv
// Word-organised RV32I data/instruction memory responder with a fixed number of
// wait states between request acceptance and a single-cycle response strobe.
module unified_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic        resp_valid,
    output logic [31:0] data_out,
    output logic        err,
    output logic        busy
);

    localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAST_WAIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, next_state;
    logic [3:0]  wait_cnt;
    logic [31:0] lat_addr, lat_data;
    logic [2:0]  lat_func3;
    logic        lat_rd, lat_wr;

    logic        accept, enter_resp, commit;
    logic [31:0] op_addr, op_data;
    logic [2:0]  op_func3;
    logic        op_rd, op_wr;
    logic        is_fetch, is_load, is_store;
    logic        bad_op, out_of_range, op_err;
    logic [IDX_W-1:0] word_idx;
    logic [31:0] rd_word, shifted, load_result, resp_data, wdata;
    logic [3:0]  be;

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (wait_cnt == LAST_WAIT) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        busy       = (state != IDLE);
        resp_valid = (state == RESP);
    end

    assign accept     = req_valid && req_ready;
    assign enter_resp = (next_state == RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt  <= 4'd0;
            lat_addr  <= 32'd0;
            lat_data  <= 32'd0;
            lat_func3 <= 3'd0;
            lat_rd    <= 1'b0;
            lat_wr    <= 1'b0;
        end else if (accept) begin
            wait_cnt  <= 4'd0;
            lat_addr  <= addr;
            lat_data  <= data_in;
            lat_func3 <= func3;
            lat_rd    <= MemRead;
            lat_wr    <= MemWrite;
        end else if (state == WAIT) begin
            wait_cnt  <= wait_cnt + 4'd1;
        end
    end

    // With zero wait states RESP is entered on the accepting edge itself,
    // so the operation must be decoded from the live inputs in that case.
    always_comb begin
        if (state == IDLE) begin
            op_addr  = addr;
            op_data  = data_in;
            op_func3 = func3;
            op_rd    = MemRead;
            op_wr    = MemWrite;
        end else begin
            op_addr  = lat_addr;
            op_data  = lat_data;
            op_func3 = lat_func3;
            op_rd    = lat_rd;
            op_wr    = lat_wr;
        end
    end

    assign is_fetch     = !op_rd && !op_wr;
    assign is_load      = op_rd && !op_wr;
    assign is_store     = op_wr && !op_rd;
    assign out_of_range = {2'b00, op_addr[31:2]} >= 32'(DEPTH_WORDS);
    assign op_err       = bad_op || out_of_range;

    always_comb begin
        bad_op = 1'b0;
        if (op_rd && op_wr) begin
            bad_op = 1'b1;
        end else if (is_fetch) begin
            bad_op = |op_addr[1:0];
        end else if (is_load) begin
            case (op_func3)
                3'b000, 3'b100: bad_op = 1'b0;
                3'b001, 3'b101: bad_op = op_addr[0];
                3'b010:         bad_op = |op_addr[1:0];
                default:        bad_op = 1'b1;
            endcase
        end else begin
            case (op_func3)
                3'b000:  bad_op = 1'b0;
                3'b001:  bad_op = op_addr[0];
                3'b010:  bad_op = |op_addr[1:0];
                default: bad_op = 1'b1;
            endcase
        end
    end

    assign word_idx = op_addr[IDX_W+1:2];
    assign rd_word  = mem[word_idx];
    assign shifted  = rd_word >> {op_addr[1:0], 3'b000};

    always_comb begin
        case (op_func3)
            3'b000:  load_result = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_result = {24'd0, shifted[7:0]};
            3'b001:  load_result = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_result = {16'd0, shifted[15:0]};
            default: load_result = rd_word;
        endcase
        if (is_fetch) load_result = rd_word;
        resp_data = (op_err || is_store) ? 32'd0 : load_result;
    end

    // Narrow stores replicate the data across lanes and rely on the byte enables.
    always_comb begin
        case (op_func3)
            3'b000: begin
                be    = 4'b0001 << op_addr[1:0];
                wdata = {4{op_data[7:0]}};
            end
            3'b001: begin
                be    = op_addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{op_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = op_data;
            end
        endcase
    end

    assign commit = enter_resp && is_store && !op_err && rst;

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= 32'd0;
            err      <= 1'b0;
        end else if (enter_resp) begin
            data_out <= resp_data;
            err      <= op_err;
        end else if (state == RESP) begin
            err      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed bench: a two-wait-state responder for the functional cases and a
// zero-wait-state responder driven back-to-back with req_valid held high.
module tb_unified_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req_valid, MemRead, MemWrite;
    logic [2:0]  func3;
    logic [31:0] addr, data_in;
    logic        req_ready, resp_valid, err, busy;
    logic [31:0] data_out;

    logic        req_valid_z, MemRead_z, MemWrite_z;
    logic [2:0]  func3_z;
    logic [31:0] addr_z, data_in_z;
    logic        req_ready_z, resp_valid_z, err_z, busy_z;
    logic [31:0] data_out_z;

    int errors = 0;
    int checks = 0;
    int resp_cnt_z = 0;

    logic        z_wr   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] z_addr [4] = '{32'h0, 32'h4, 32'h0, 32'h4};
    logic [31:0] z_data [4] = '{32'h01010101, 32'h02020202, 32'h0, 32'h0};
    logic [31:0] z_exp  [4] = '{32'h0, 32'h0, 32'h01010101, 32'h02020202};

    unified_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .func3(func3),
        .addr(addr), .data_in(data_in),
        .resp_valid(resp_valid), .data_out(data_out), .err(err), .busy(busy)
    );

    unified_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_z), .req_ready(req_ready_z),
        .MemRead(MemRead_z), .MemWrite(MemWrite_z), .func3(func3_z),
        .addr(addr_z), .data_in(data_in_z),
        .resp_valid(resp_valid_z), .data_out(data_out_z), .err(err_z), .busy(busy_z)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (resp_valid_z === 1'b1) resp_cnt_z++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction on the two-wait-state instance: accept, latency, result.
    task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                                 input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] d, input logic [31:0] exp_data,
                                 input logic exp_err);
        int cycles;
        @(negedge clk);
        checkOutput({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        MemRead   = rd;
        MemWrite  = wr;
        func3     = f3;
        addr      = a;
        data_in   = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        addr      = 32'hFFFF_FFFC;
        data_in   = 32'h5A5A_5A5A;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (resp_valid !== 1'b1 && cycles < 20);
        checkOutput({tag, " latency"}, 32'(cycles), 32'd3);
        checkOutput({tag, " data"}, data_out, exp_data);
        checkOutput({tag, " err"}, 32'(err), 32'(exp_err));
        @(negedge clk);
        checkOutput({tag, " one-shot"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        req_valid = 0; MemRead = 0; MemWrite = 0; func3 = 0; addr = 0; data_in = 0;
        req_valid_z = 0; MemRead_z = 0; MemWrite_z = 0; func3_z = 0; addr_z = 0; data_in_z = 0;

        #12;
        checkOutput("reset ready", 32'(req_ready), 32'd1);
        checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset err", 32'(err), 32'd0);
        checkOutput("reset data_out", data_out, 32'd0);
        checkOutput("reset busy z", 32'(busy_z), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus("SW 0x10", 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        applyStimulus("LW 0x10", 1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        applyStimulus("fetch 0x10", 0, 0, 3'b111, 32'h10, 32'h0, 32'hDEADBEEF, 0);

        applyStimulus("SW 0x20", 0, 1, 3'b010, 32'h20, 32'h000080F0, 32'h0, 0);
        applyStimulus("LB 0x20", 1, 0, 3'b000, 32'h20, 32'h0, 32'hFFFFFFF0, 0);
        applyStimulus("LBU 0x21", 1, 0, 3'b100, 32'h21, 32'h0, 32'h00000080, 0);
        applyStimulus("LH 0x20", 1, 0, 3'b001, 32'h20, 32'h0, 32'hFFFF80F0, 0);
        applyStimulus("LHU 0x20", 1, 0, 3'b101, 32'h20, 32'h0, 32'h000080F0, 0);

        applyStimulus("SW 0x30", 0, 1, 3'b010, 32'h30, 32'h11223344, 32'h0, 0);
        applyStimulus("SB 0x32", 0, 1, 3'b000, 32'h32, 32'h000000AA, 32'h0, 0);
        applyStimulus("LW 0x30", 1, 0, 3'b010, 32'h30, 32'h0, 32'h11AA3344, 0);
        applyStimulus("SW 0x34", 0, 1, 3'b010, 32'h34, 32'h0, 32'h0, 0);
        applyStimulus("SH 0x36", 0, 1, 3'b001, 32'h36, 32'h1234BEEF, 32'h0, 0);
        applyStimulus("LW 0x34", 1, 0, 3'b010, 32'h34, 32'h0, 32'hBEEF0000, 0);

        applyStimulus("LH 0x21 misaligned", 1, 0, 3'b001, 32'h21, 32'h0, 32'h0, 1);
        applyStimulus("LW 0x10 refill", 1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        applyStimulus("SW 0x13 misaligned", 0, 1, 3'b010, 32'h13, 32'h0, 32'h0, 1);
        applyStimulus("LW 0x1000 range", 1, 0, 3'b010, 32'h1000, 32'h0, 32'h0, 1);
        applyStimulus("load f3 011", 1, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1);
        applyStimulus("rd+wr", 1, 1, 3'b010, 32'h10, 32'h12345678, 32'h0, 1);
        applyStimulus("store f3 011", 0, 1, 3'b011, 32'h10, 32'h0BADCAFE, 32'h0, 1);
        applyStimulus("fetch 0x22 misaligned", 0, 0, 3'b010, 32'h22, 32'h0, 32'h0, 1);
        applyStimulus("LW 0x10 unchanged", 1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        applyStimulus("LW 0x20 unchanged", 1, 0, 3'b010, 32'h20, 32'h0, 32'h000080F0, 0);

        applyStimulus("SW 0x40", 0, 1, 3'b010, 32'h40, 32'hAAAA5555, 32'h0, 0);
        applyStimulus("LW 0x40", 1, 0, 3'b010, 32'h40, 32'h0, 32'hAAAA5555, 0);

        // Abort a store in WAIT with reset and confirm nothing was written.
        @(negedge clk);
        req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; func3 = 3'b010;
        addr = 32'h40; data_in = 32'h0BADF00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checkOutput("abort busy in WAIT", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("abort ready", 32'(req_ready), 32'd1);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort err", 32'(err), 32'd0);
        checkOutput("abort data_out", data_out, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("abort no resp", 32'(resp_valid), 32'd0);
        end
        rst = 1'b1;
        applyStimulus("LW 0x40 after abort", 1, 0, 3'b010, 32'h40, 32'h0, 32'hAAAA5555, 0);

        // Zero wait states, req_valid held high across four requests.
        @(negedge clk);
        checkOutput("z ready", 32'(req_ready_z), 32'd1);
        req_valid_z = 1'b1;
        MemRead_z = ~z_wr[0]; MemWrite_z = z_wr[0]; func3_z = 3'b010;
        addr_z = z_addr[0]; data_in_z = z_data[0];
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("z resp_valid", 32'(resp_valid_z), 32'd1);
            checkOutput("z busy high", 32'(busy_z), 32'd1);
            checkOutput("z data", data_out_z, z_exp[k]);
            checkOutput("z err", 32'(err_z), 32'd0);
            if (k < 3) begin
                MemRead_z = ~z_wr[k+1]; MemWrite_z = z_wr[k+1];
                addr_z = z_addr[k+1]; data_in_z = z_data[k+1];
            end else begin
                req_valid_z = 1'b0;
            end
            @(negedge clk);
            checkOutput("z idle resp", 32'(resp_valid_z), 32'd0);
            checkOutput("z busy low", 32'(busy_z), 32'd0);
        end
        repeat (3) @(negedge clk);
        checkOutput("z response count", 32'(resp_cnt_z), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
